// File: rtl/cnt_capture_ext_pkg.sv
// Shared definitions for the ripple-count capture block: count width,
// snapshot FSM states and the wrap comparison.
package cnt_capture_ext_pkg;

  localparam int CNT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_t;

  // A ripple up-counter only ever moves forward, so a lower accepted value means it wrapped.
  function automatic logic is_wrap(input logic [CNT_W-1:0] new_val,
                                   input logic [CNT_W-1:0] old_val);
    return new_val < old_val;
  endfunction

endpackage

// File: rtl/cnt_capture_ext_if.sv
// Snapshot handshake bundle: the reader drives req/ready, the capture block
// returns valid plus the {ext, acc} snapshot.
interface cnt_capture_ext_if #(parameter int EXT_W = 8);
  import cnt_capture_ext_pkg::*;

  localparam int TOT_W = EXT_W + CNT_W;

  logic             snap_req;
  logic             snap_ready;
  logic             snap_valid;
  logic [TOT_W-1:0] snap_data;

  modport master (output snap_req, snap_ready, input snap_valid, snap_data);
  modport slave  (input snap_req, snap_ready, output snap_valid, snap_data);

endinterface

// File: rtl/cnt_capture_ext_stab_filter.sv
// Settling filter for the raw ripple count: a value must match at two
// consecutive edges before it replaces the accepted count.
module cnt_stab_filter
  import cnt_capture_ext_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [CNT_W-1:0] acc,
  output logic             accept,
  output logic             wrap_det
);

  logic [CNT_W-1:0] s1;
  logic [CNT_W-1:0] s2;

  // Strobes are valid in the cycle before the edge that loads the new value.
  always_comb begin
    accept   = (s1 == s2) && (s1 != acc);
    wrap_det = accept && is_wrap(s1, acc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1  <= '0;
      s2  <= '0;
      acc <= '0;
    end else begin
      s1 <= cnt_in;
      s2 <= s1;
      if (accept) begin
        acc <= s1;
      end
    end
  end

endmodule

// File: rtl/cnt_capture_ext.sv
// Extends the filtered 3-bit ripple count with a wrap counter, flags overflow
// and hands out atomic {ext, acc} snapshots over a valid/ready handshake.
module cnt_capture_ext
  import cnt_capture_ext_pkg::*;
#(
  parameter int EXT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CNT_W-1:0]        cnt_in,
  input  logic                    clr,
  cnt_capture_ext_if.slave        snap,
  output logic [CNT_W-1:0]        cnt_stable,
  output logic                    wrap,
  output logic                    ovf
);

  localparam int TOT_W = EXT_W + CNT_W;

  logic [CNT_W-1:0] acc;
  logic             accept;
  logic             wrap_det;
  logic             wrap_hit;
  logic [EXT_W-1:0] ext;
  logic [TOT_W-1:0] data_q;
  snap_state_t      state_q;
  snap_state_t      state_d;
  logic             capture;
  logic             valid;

  cnt_stab_filter u_filter (
    .clk      (clk),
    .rst      (rst),
    .cnt_in   (cnt_in),
    .acc      (acc),
    .accept   (accept),
    .wrap_det (wrap_det)
  );

  assign wrap_hit   = accept && wrap_det;
  assign cnt_stable = acc;

  // clr has priority over a coincident wrap; the wrap pulse still fires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext  <= '0;
      ovf  <= 1'b0;
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_hit;
      if (clr) begin
        ext <= '0;
        ovf <= 1'b0;
      end else if (wrap_hit) begin
        ext <= ext + 1'b1;
        if (&ext) begin
          ovf <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (snap.snap_req) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        valid = 1'b1;
        if (snap.snap_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture uses the pre-update ext/acc so a snapshot never mixes two counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        data_q <= {ext, acc};
      end
    end
  end

  assign snap.snap_valid = valid;
  assign snap.snap_data  = data_q;

endmodule

// File: tb/tb_cnt_capture_ext.sv
// Bench for cnt_capture_ext: EXT_W=8 and EXT_W=2 instances share stimulus and
// are compared every cycle against a wrap-counting reference model.
module tb_cnt_capture_ext;
  import cnt_capture_ext_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cnt_in;
  logic       clr;
  logic       snap_req;
  logic       snap_ready;
  logic [2:0] stable8, stable2;
  logic       wrap8, wrap2, ovf8, ovf2;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: sampled history, accepted value, wraps since last clr.
  int samples[$];
  int acc_m, wraps_m, snap_acc_m, snap_wraps_m, wrap_seen;
  bit wrap_m, valid_m;

  cnt_capture_ext_if #(.EXT_W(8)) if8 ();
  cnt_capture_ext_if #(.EXT_W(2)) if2 ();

  assign if8.snap_req   = snap_req;
  assign if8.snap_ready = snap_ready;
  assign if2.snap_req   = snap_req;
  assign if2.snap_ready = snap_ready;

  cnt_capture_ext #(.EXT_W(8)) dut8 (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr), .snap(if8.slave),
    .cnt_stable(stable8), .wrap(wrap8), .ovf(ovf8)
  );

  cnt_capture_ext #(.EXT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr), .snap(if2.slave),
    .cnt_stable(stable2), .wrap(wrap2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    samples.delete();
    samples.push_back(0);
    samples.push_back(0);
    acc_m = 0; wraps_m = 0; wrap_m = 0; valid_m = 0;
    snap_acc_m = 0; snap_wraps_m = 0;
  endtask

  // A value seen at the last two edges is accepted; a drop in value is a wrap.
  task automatic model_step();
    int acc_old, wraps_old;
    bit take;
    acc_old   = acc_m;
    wraps_old = wraps_m;
    take      = (samples[0] == samples[1]) && (samples[1] != acc_m);
    wrap_m    = take && (samples[1] < acc_m);
    if (take) acc_m = samples[1];
    if (clr) wraps_m = 0;
    else if (wrap_m) wraps_m++;
    if (!valid_m && snap_req) begin
      valid_m      = 1;
      snap_acc_m   = acc_old;
      snap_wraps_m = wraps_old;
    end else if (valid_m && snap_ready) begin
      valid_m = 0;
    end
    samples.push_back(int'(cnt_in));
    void'(samples.pop_front());
  endtask

  task automatic check_output();
    check_val("cnt_stable8", 32'(stable8), acc_m);
    check_val("cnt_stable2", 32'(stable2), acc_m);
    check_val("wrap8", 32'(wrap8), 32'(wrap_m));
    check_val("wrap2", 32'(wrap2), 32'(wrap_m));
    check_val("ovf8", 32'(ovf8), 32'(wraps_m >= 256));
    check_val("ovf2", 32'(ovf2), 32'(wraps_m >= 4));
    check_val("snap_valid8", 32'(if8.snap_valid), 32'(valid_m));
    check_val("snap_valid2", 32'(if2.snap_valid), 32'(valid_m));
    check_val("snap_data8", 32'(if8.snap_data), ((snap_wraps_m % 256) * 8) + snap_acc_m);
    check_val("snap_data2", 32'(if2.snap_data), ((snap_wraps_m % 4) * 8) + snap_acc_m);
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic apply_stimulus(input logic [2:0] c, input logic cl, input logic rq, input logic rd);
    cnt_in     = c;
    clr        = cl;
    snap_req   = rq;
    snap_ready = rd;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_output();
  endtask

  task automatic hold(input logic [2:0] c, input int n);
    for (int k = 0; k < n; k++) apply_stimulus(c, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; cnt_in = '0; clr = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check_output();
    @(negedge clk);
    rst = 1'b1;

    // Full count 0..7 then 0: exactly one wrap, snapshot {ext=1, acc=0}
    wrap_seen = 0;
    for (int v = 0; v <= 8; v++) begin
      for (int k = 0; k < 4; k++) begin
        apply_stimulus(3'(v % 8), 1'b0, 1'b0, 1'b0);
        wrap_seen += int'(wrap8);
      end
    end
    check_val("tp1_wrap_count", wrap_seen, 1);
    apply_stimulus(3'd0, 1'b0, 1'b1, 1'b0);
    check_val("tp1_snap_data", 32'(if8.snap_data), 32'h008);
    check_val("tp1_ovf", 32'(ovf8), 0);
    apply_stimulus(3'd0, 1'b0, 1'b0, 1'b1);
    check_val("tp1_valid_drop", 32'(if8.snap_valid), 0);

    // Single-cycle glitch is rejected; a 6->1 skip is one wrap
    hold(3'd2, 4);
    apply_stimulus(3'd3, 1'b0, 1'b0, 1'b0);
    wrap_seen = 0;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(3'd2, 1'b0, 1'b0, 1'b0);
      check_val("glitch_stable", 32'(stable8), 2);
      wrap_seen += int'(wrap8);
    end
    check_val("glitch_no_wrap", wrap_seen, 0);
    hold(3'd6, 4);
    wrap_seen = 0;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(3'd1, 1'b0, 1'b0, 1'b0);
      wrap_seen += int'(wrap8);
    end
    check_val("skip_wrap_count", wrap_seen, 1);

    // Four wraps overflow the 2-bit extension only
    apply_stimulus(3'd1, 1'b1, 1'b0, 1'b0);
    for (int w = 0; w < 4; w++) begin
      hold(3'd7, 3);
      hold(3'd0, 3);
    end
    check_val("ovf2_set", 32'(ovf2), 1);
    check_val("ovf8_clear", 32'(ovf8), 0);
    apply_stimulus(3'd0, 1'b0, 1'b1, 1'b0);
    check_val("ovf2_ext_zero", 32'(if2.snap_data), 32'h00);
    check_val("ovf8_ext_four", 32'(if8.snap_data), 32'h020);
    apply_stimulus(3'd0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(3'd0, 1'b1, 1'b0, 1'b0);
    check_val("clr_ovf2", 32'(ovf2), 0);

    // clr coinciding with a wrap: pulse fires, extension ends at zero
    hold(3'd7, 3);
    hold(3'd0, 3);
    hold(3'd7, 3);
    apply_stimulus(3'd0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(3'd0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(3'd0, 1'b1, 1'b0, 1'b0);
    check_val("clr_wrap_pulse", 32'(wrap8), 1);
    apply_stimulus(3'd0, 1'b0, 1'b1, 1'b0);
    check_val("clr_wrap_ext8", 32'(if8.snap_data), 32'h000);
    apply_stimulus(3'd0, 1'b0, 1'b0, 1'b1);

    // Snapshot held stable while the count moves and a second request arrives
    hold(3'd4, 3);
    apply_stimulus(3'd4, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(3'(5 + k / 2), 1'b0, (k == 2), 1'b0);
      check_val("hold_valid", 32'(if8.snap_valid), 1);
      check_val("hold_data", 32'(if8.snap_data), 32'h004);
    end
    apply_stimulus(3'd7, 1'b0, 1'b0, 1'b1);
    check_val("hold_release", 32'(if8.snap_valid), 0);

    // Request on the same edge as a 7->0 acceptance sees the old values
    hold(3'd7, 3);
    apply_stimulus(3'd0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(3'd0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(3'd0, 1'b0, 1'b1, 1'b0);
    check_val("pre_update_snap", 32'(if8.snap_data), 32'h007);
    check_val("pre_update_wrap", 32'(wrap8), 1);

    // Asynchronous reset while holding a snapshot
    hold(3'd5, 3);
    #2 rst = 1'b0;
    #1 model_reset();
    check_output();
    check_val("async_valid", 32'(if8.snap_valid), 0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      logic [2:0] c;
      int n;
      c = 3'($urandom_range(7, 0));
      n = int'($urandom_range(3, 1));
      for (int k = 0; k < n; k++) begin
        apply_stimulus(c, ($urandom_range(31, 0) == 0), ($urandom_range(3, 0) == 0),
                       ($urandom_range(1, 0) == 1));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt_capture_ext.md
# cnt_capture_ext

Downstream consumer of the 3-bit JK ripple up-counter. Samples the raw ripple count, filters settling glitches, and detects wrap-around. It extends the count to a wider total, sets a sticky overflow flag, and returns atomic snapshots of the total through a valid/ready handshake. It sits between the ripple counter and any synchronous reader such as a display or bus register.

## Interface
- EXT_W, 8, width of the wrap-extension counter; total width TOT_W = EXT_W + 3
- clk  in  1  system clock; every register updates on the rising edge
- rst  in  1  reset, asynchronous and active-low; clears all state
- cnt_in  in  3  raw ripple-counter value; may glitch while it settles
- clr  in  1  synchronous clear of extension counter and ovf
- snap_req  in  1  snapshot request, sampled in IDLE only
- snap_ready  in  1  consumer accepts snapshot
- snap_valid  out  1  snapshot data valid
- snap_data  out  TOT_W  captured {ext, acc}
- cnt_stable  out  3  filtered count (acc)
- wrap  out  1  one-cycle pulse per detected wrap
- ovf  out  1  sticky; set when ext wraps

## Operation
- Filter: two-stage sample s1 <= cnt_in; s2 <= s1. When s1 == s2 and s1 != acc, then acc <= s1. A value must be identical at two consecutive edges before it is accepted.
- Wrap detect: an acceptance where the new value is less than acc counts as one wrap. Examples: 7->0, and also the skip 6->1.
- On wrap: ext <= ext + 1 modulo 2^EXT_W, and wrap = 1 for that cycle.
- If ext is all-ones on a wrap, ext becomes 0 and ovf <= 1. ovf stays set until clr or rst.
- clr: ext <= 0, ovf <= 0. clr does not touch acc, s1 or s2. If clr and a wrap occur in the same cycle, clr wins: ext = 0 and ovf = 0. The wrap pulse still fires.
- Handshake FSM:
  - IDLE: snap_valid = 0. When snap_req = 1, capture snap_data <= {ext, acc} using the pre-update register values at that edge, then go to HOLD.
  - HOLD: snap_valid = 1 and snap_data is held stable. snap_req is ignored. When snap_ready = 1 at an edge, go to IDLE.
- Reset values: s1 = s2 = acc = 0, ext = 0, ovf = 0, wrap = 0, snap_valid = 0, snap_data = 0, state IDLE.

## Timing
- cnt_in settles before edge N: s1 at N, s2 at N+1, acc/cnt_stable updated at N+2. wrap is high in the cycle after edge N+2, and ext is updated at the same edge.
- A one-cycle glitch on cnt_in is never accepted.
- Snapshot latency: snap_req sampled at edge M gives snap_valid = 1 after M.
- A transfer occurs at the edge where snap_valid and snap_ready are both 1. snap_valid is 0 after that edge.
- Back-to-back snapshots: a new snap_req is accepted at the first edge in which the FSM is in IDLE.
- Asserting rst mid-HOLD drops snap_valid and clears all outputs immediately, without waiting for clk. After rst deasserts, the first update occurs at the next rising edge.

## Structure
- Shared package: CNT_W = 3; state encoding IDLE = 1'b0, HOLD = 1'b1.
- One sub-module, cnt_stab_filter: holds s1, s2 and acc, and outputs acc plus a one-cycle accept strobe and a wrap strobe.
- Top level holds ext, ovf, the handshake FSM and snap_data.

## Test plan
- Reset, then step cnt_in 0..7 then 0, holding each value 4 cycles -> exactly one wrap pulse. Then snap_req -> snap_data = 11'h008, ovf = 0.
- cnt_in = 2, then a single cycle at 3, then back to 2 -> cnt_stable stays 2 and wrap never asserts. Skip 6 -> 1 (held) -> one wrap.
- EXT_W = 2, four full wraps -> ext = 0 and ovf = 1. Pulse clr -> ovf = 0. clr in the same cycle as a wrap -> ext = 0.
- snap_req with snap_ready low for 5 cycles while the count keeps changing -> snap_data constant and the second snap_req is ignored. Raise snap_ready -> snap_valid = 0 after the next edge.
- Assert rst mid-HOLD, asynchronously between edges -> snap_valid, snap_data, cnt_stable, ext and ovf are all 0 before the next clk edge.
- snap_req in the same cycle as a 7->0 acceptance -> snapshot shows the pre-update values {ext_old, 3'd7}.
